// File: rtl/counting_pkg.sv
// Shared constants and helpers for the ring-oscillator frequency meter.
`timescale 1ns/1ps
package counting_pkg;

  localparam int GATE_CYCLES_DEF = 256;
  localparam int COUNT_W_DEF     = 16;

  // Width of the generic arithmetic used by sat_inc. Callers zero-extend into it.
  localparam int SAT_W = 64;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] max_val,
                                               input logic             inc);
    if (inc && (val < max_val)) begin
      return val + SAT_W'(1);
    end
    return val;
  endfunction

endpackage

// File: rtl/ring_sync_edge.sv
// Brings the free-running ring output into the clk domain and flags its rising edges.
`timescale 1ns/1ps
module ring_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic s1_d, s2_d, s3_d;
  logic s1_q, s2_q, s3_q;

  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // s1/s2 form the synchronizer; s3 is the one-cycle history for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/counting_circuit.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of Ring_in
// over a fixed gate window and publishes the saturated count at window end.
`timescale 1ns/1ps
module counting_circuit
  import counting_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int COUNT_W     = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Ring_in,
  output logic [COUNT_W-1:0] value_out
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [SAT_W-1:0]  COUNT_MAX = SAT_W'({COUNT_W{1'b1}});

  logic               rise;
  logic               window_end;
  logic [COUNT_W-1:0] edge_next;
  logic [GATE_W-1:0]  gate_cnt_d, gate_cnt_q;
  logic [COUNT_W-1:0] edge_cnt_d, edge_cnt_q;
  logic [COUNT_W-1:0] value_d, value_q;

  ring_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (Ring_in),
    .rise_pulse (rise)
  );

  // An edge detected in the closing cycle is folded into the published value.
  always_comb begin
    window_end = (gate_cnt_q == GATE_LAST);
    edge_next  = COUNT_W'(sat_inc(SAT_W'(edge_cnt_q), COUNT_MAX, rise));
    gate_cnt_d = window_end ? '0 : gate_cnt_q + GATE_W'(1);
    edge_cnt_d = window_end ? '0 : edge_next;
    value_d    = window_end ? edge_next : value_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      value_q    <= '0;
    end else begin
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      value_q    <= value_d;
    end
  end

  assign value_out = value_q;

endmodule

// File: tb/tb_counting_circuit.sv
// Randomized and directed checks of counting_circuit against an edge-credit model.
`timescale 1ns/1ps
module tb_counting_circuit;

  localparam int GATE     = 16;
  localparam int GATE_SAT = 64;
  localparam int MAX_A    = 65535;
  localparam int SAT_MAX  = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ring_a = 1'b0;
  logic        ring_sat = 1'b0;
  logic [15:0] value_a;
  logic [3:0]  value_sat;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;
  bit sat_on = 1'b0;

  // Model: every sampled 0->1 of the input earns a credit that lands two edges
  // later; credits landing inside a window are totalled at its last edge.
  int edge_num;
  int win_count;
  int exp_value;
  bit prev_sample;
  int credits[$];
  int sq_phase;

  always #10 clk = ~clk;

  counting_circuit #(.GATE_CYCLES(GATE), .COUNT_W(16)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .Ring_in   (ring_a),
    .value_out (value_a)
  );

  counting_circuit #(.GATE_CYCLES(GATE_SAT), .COUNT_W(4)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .Ring_in   (ring_sat),
    .value_out (value_sat)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    edge_num    = 0;
    win_count   = 0;
    exp_value   = 0;
    prev_sample = 1'b0;
    credits.delete();
  endtask

  task automatic modelStep();
    edge_num++;
    if (ring_a && !prev_sample) credits.push_back(edge_num + 2);
    prev_sample = ring_a;
    while (credits.size() > 0 && credits[0] == edge_num) begin
      win_count++;
      void'(credits.pop_front());
    end
    if (edge_num % GATE == 0) begin
      exp_value = (win_count > MAX_A) ? MAX_A : win_count;
      win_count = 0;
    end
  endtask

  // One clk cycle: account for the posedge just passed, compare, then drive.
  task automatic applyStimulus(input logic ring_val);
    @(negedge clk);
    if (!rst) modelStep();
    if (model_on) checkOutput("window", 32'(value_a), 32'(exp_value));
    if (sat_on) begin
      if (edge_num == GATE_SAT - 1) checkOutput("satBefore", 32'(value_sat), 0);
      if (edge_num == GATE_SAT || edge_num == 2 * GATE_SAT || edge_num == 2 * GATE_SAT + 5)
        checkOutput("satHold", 32'(value_sat), SAT_MAX);
      ring_sat = ~ring_sat;
    end else begin
      ring_sat = 1'b0;
    end
    ring_a = ring_val;
  endtask

  function automatic logic squareBit(input int phase);
    return (phase % 4) < 2;
  endfunction

  initial begin
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rstA", 32'(value_a), 0);
    checkOutput("rstSat", 32'(value_sat), 0);

    rst = 1'b0;
    ring_sat = 1'b1;
    sat_on = 1'b1;
    model_on = 1'b1;

    $display("[TB] idle input");
    repeat (48) applyStimulus(1'b0);
    checkOutput("idle", 32'(value_a), 0);

    $display("[TB] synchronous square wave");
    for (int c = 0; c < 96; c++) applyStimulus(squareBit(c));
    checkOutput("square", 32'(value_a), 4);
    sat_on = 1'b0;

    $display("[TB] random synchronous input");
    for (int c = 0; c < 160; c++) applyStimulus(1'($urandom_range(0, 1)));
    repeat (36) applyStimulus(1'b0);
    checkOutput("flush", 32'(value_a), 0);

    $display("[TB] edge detected in last window cycle");
    for (int i = 0; i < GATE && (edge_num % GATE) != 13; i++) applyStimulus(1'b0);
    checkOutput("alignLast", 32'(edge_num % GATE), 13);
    ring_a = 1'b1;
    repeat (2) applyStimulus(1'b0);
    checkOutput("beforeLast", 32'(value_a), 0);
    applyStimulus(1'b0);
    checkOutput("lastCycle", 32'(value_a), 1);
    repeat (16) applyStimulus(1'b0);
    checkOutput("nextWindow", 32'(value_a), 0);

    $display("[TB] reset in the middle of a window");
    sq_phase = 0;
    repeat (40) begin
      applyStimulus(squareBit(sq_phase));
      sq_phase++;
    end
    for (int i = 0; i < GATE && (edge_num % GATE) != 7; i++) begin
      applyStimulus(squareBit(sq_phase));
      sq_phase++;
    end
    checkOutput("alignRst", 32'(edge_num % GATE), 7);
    checkOutput("preRst", 32'(value_a), 4);
    #3;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("rstAsync", 32'(value_a), 0);
    ring_a = 1'b0;
    repeat (2) applyStimulus(1'b0);
    rst = 1'b0;
    for (int n = 1; n <= 15; n++) applyStimulus(squareBit(n + 2));
    checkOutput("postRstHold", 32'(value_a), 0);
    applyStimulus(squareBit(18));
    checkOutput("postRst", 32'(value_a), 3);
    for (int n = 17; n <= 40; n++) applyStimulus(squareBit(n + 2));

    $display("[TB] asynchronous ring input");
    model_on = 1'b0;
    fork
      begin
        #4.5;
        repeat (300) begin
          ring_a = ~ring_a;
          #9;
        end
      end
    join_none
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      checkOutput("asyncX", 32'($isunknown(value_a)), 0);
      checkOutput("asyncMax", 32'(value_a <= 16'd8), 1);
      if (i >= 40) checkOutput("asyncNonzero", 32'(value_a != 16'd0), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
